// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, the hard-wired zero
// register index and the operand address/data types.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Address 0 always reads zero, and the port reads zero while rst is high.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, the port
// forwards same-cycle write data (lane 2 over lane 1 over stored value).
module regfile_read_port
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
  input  logic              we_1,
  input  logic [ADDR_W-1:0] wr_1,
  input  logic [DATA_W-1:0] wb_1,
  input  logic              we_2,
  input  logic [ADDR_W-1:0] wr_2,
  input  logic [DATA_W-1:0] wb_2,
`endif
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Select the read value: zero for r0 or reset, else (forwarded or) stored data
  always_comb begin
    data = '0;
    if (!rst && addr != ZERO_ADDR) begin
`ifdef REGFILE_BYPASS_EN
      if (we_2 && wr_2 == addr) begin
        data = wb_2;
      end else if (we_1 && wr_1 == addr) begin
        data = wb_1;
      end else begin
        data = stored;
      end
`else
      data = stored;
`endif
    end
  end

endmodule

// File: rtl/reg_file_dual.sv
// Dual-write, quad-read integer register file. Writes commit on the rising
// edge of clk; reads are combinational through four regfile_read_port
// instances. Register 0 is never written and always reads zero.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding).
module reg_file_dual
  import core_pkg::*;
#(
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int ADDR_W   = core_pkg::ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] WR_mux_1,
  input  logic [DATA_W-1:0] WB_mux_1,
  input  logic              we_2,
  input  logic [ADDR_W-1:0] WR_mux_2,
  input  logic [DATA_W-1:0] WB_mux_2,
  input  logic [ADDR_W-1:0] rs_1,
  input  logic [ADDR_W-1:0] rt_1,
  input  logic [ADDR_W-1:0] rs_2,
  input  logic [ADDR_W-1:0] rt_2,
  output logic [DATA_W-1:0] dato_rs_1,
  output logic [DATA_W-1:0] dato_rt_1,
  output logic [DATA_W-1:0] dato_rs_2,
  output logic [DATA_W-1:0] dato_rt_2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam int NUM_PORTS = 4;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [ADDR_W-1:0] rd_addr [NUM_PORTS];
  logic [DATA_W-1:0] rd_data [NUM_PORTS];

  // Storage: async clear; lane 2 is issued after lane 1 so its write is
  // placed last and overrides lane 1 on a same-address conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we_1 && WR_mux_1 != ZERO_ADDR) begin
        regs[WR_mux_1] <= WB_mux_1;
      end
      if (we_2 && WR_mux_2 != ZERO_ADDR) begin
        regs[WR_mux_2] <= WB_mux_2;
      end
    end
  end

  // Gather the four read addresses so the ports can be generated uniformly
  always_comb begin
    rd_addr[0] = rs_1;
    rd_addr[1] = rt_1;
    rd_addr[2] = rs_2;
    rd_addr[3] = rt_2;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .rst    (rst),
      .addr   (rd_addr[p]),
      .stored (regs[rd_addr[p]]),
`ifdef REGFILE_BYPASS_EN
      .we_1   (we_1),
      .wr_1   (WR_mux_1),
      .wb_1   (WB_mux_1),
      .we_2   (we_2),
      .wr_2   (WR_mux_2),
      .wb_2   (WB_mux_2),
`endif
      .data   (rd_data[p])
    );
  end

  // Route port results to the named outputs
  always_comb begin
    dato_rs_1 = rd_data[0];
    dato_rt_1 = rd_data[1];
    dato_rs_2 = rd_data[2];
    dato_rt_2 = rd_data[3];
  end

endmodule
